// File: rtl/prng_lcg_fifo_if.sv
// prng_lcg_fifo_if: command and random-word handshake bundle.
// master drives cmd_*/rn_rdy; slave (the generator) drives the rest.
interface prng_lcg_fifo_if #(
    parameter int SEED_W = 32,
    parameter int OUT_W  = 15,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              cmd_vld;
    logic [1:0]        cmd_typ;
    logic [SEED_W-1:0] cmd_dat;
    logic              cmd_rdy;
    logic              rn_vld;
    logic [OUT_W-1:0]  rn_dat;
    logic              rn_rdy;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              busy;

    modport master (
        output cmd_vld, cmd_typ, cmd_dat, rn_rdy,
        input  cmd_rdy, rn_vld, rn_dat, fifo_cnt, busy
    );

    modport slave (
        input  cmd_vld, cmd_typ, cmd_dat, rn_rdy,
        output cmd_rdy, rn_vld, rn_dat, fifo_cnt, busy
    );
endinterface

// File: rtl/prng_lcg_fifo.sv
// prng_lcg_fifo: LCG random generator feeding a show-ahead FIFO.
// Ports: clk, rst_b (async, active-low), bus (slave): cmd_* command
// port, rn_* pop handshake, fifo_cnt occupancy, busy step in flight.
module prng_lcg_fifo #(
    parameter int              SEED_W  = 32,
    parameter logic [SEED_W-1:0] MUL_A = SEED_W'(1103515245),
    parameter logic [SEED_W-1:0] INC_C = SEED_W'(12345),
    parameter int              OUT_LSB = 16,
    parameter int              OUT_W   = 15,
    parameter int              MUL_LAT = 1,
    parameter int              DEPTH   = 4
) (
    input logic             clk,
    input logic             rst_b,
    prng_lcg_fifo_if.slave  bus
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam int LW    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [LW-1:0]    LAT_END = LW'(MUL_LAT - 1);

    localparam logic [1:0] C_HALT = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_LOAD = 2'd2;

    typedef enum logic {IDLE, MUL} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SEED_W-1:0] seed;
    logic [SEED_W-1:0] prod;
    logic              run;
    logic [LW-1:0]     lat;
    logic [OUT_W-1:0]  mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CNT_W-1:0]  cnt;
    logic [OUT_W-1:0]  last;

    logic cmd_acc;
    logic empty_acc;
    logic pop;
    logic launch;
    logic push;

    assign cmd_acc   = bus.cmd_vld && bus.cmd_rdy;
    // LOAD (2) and FLUSH (3) both empty the FIFO.
    assign empty_acc = cmd_acc && bus.cmd_typ[1];
    // An accepted command takes priority over a pop.
    assign pop       = bus.rn_vld && bus.rn_rdy && !cmd_acc;

    assign bus.busy     = (state == MUL);
    assign bus.cmd_rdy  = (state != MUL);
    assign bus.rn_vld   = (cnt != '0);
    assign bus.fifo_cnt = cnt;
    // When empty the output holds the last head that was shown.
    assign bus.rn_dat   = bus.rn_vld ? mem[rptr] : last;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (run && cnt != FULL && !cmd_acc) begin
                    launch    = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (lat == LAT_END) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Product is captured at launch and held for MUL_LAT cycles,
    // giving the multiply that many cycles to settle or retime.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lat  <= '0;
            prod <= '0;
            seed <= '0;
            run  <= 1'b0;
        end else begin
            if (launch)          lat <= '0;
            else if (state == MUL) lat <= lat + 1'b1;
            if (launch) prod <= seed * MUL_A + INC_C;
            if (cmd_acc && bus.cmd_typ == C_LOAD) seed <= bus.cmd_dat;
            else if (push)                        seed <= prod;
            if (cmd_acc && bus.cmd_typ == C_RUN)       run <= 1'b1;
            else if (cmd_acc && (bus.cmd_typ == C_HALT ||
                                 bus.cmd_typ == C_LOAD)) run <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= prod[OUT_LSB +: OUT_W];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            last <= '0;
        end else if (empty_acc) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            if (cnt != '0) last <= mem[rptr];
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr <= rptr + 1'b1;
                last <= mem[rptr];
            end
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end
endmodule
